// File: rtl/keying_modulator_if.sv
// Carrier/code/control bundle for the keying modulator.
interface keying_modulator_if #(
  parameter int DATA_W  = 16,
  parameter int SEQ_LEN = 16,
  parameter int DIV_W   = 32
);
  localparam int IDX_W = $clog2(SEQ_LEN);

  logic               enable;
  logic [1:0]         mode;
  logic [DIV_W-1:0]   symbol_div;
  logic [DATA_W-1:0]  carrier;
  logic [SEQ_LEN-1:0] sequence_code;
  logic [DATA_W-1:0]  mod_sig;
  logic               sym_bit;
  logic [IDX_W-1:0]   bit_index;
  logic               symbol_strobe;
  logic               frame_done;
  logic               zc_timeout;

  modport master (
    output enable, mode, symbol_div, carrier, sequence_code,
    input  mod_sig, sym_bit, bit_index, symbol_strobe, frame_done, zc_timeout
  );

  modport slave (
    input  enable, mode, symbol_div, carrier, sequence_code,
    output mod_sig, sym_bit, bit_index, symbol_strobe, frame_done, zc_timeout
  );
endinterface

// File: rtl/keying_modulator.sv
// Keys an offset-binary DDS carrier with a serial code word (OOK / ASK / BPSK /
// hold). Symbol advances are deferred to a carrier mid-scale crossing, with a
// timeout fallback so a DC-ish carrier cannot stall the sequence.
module keying_modulator #(
  parameter int DATA_W     = 16,
  parameter int SEQ_LEN    = 16,
  parameter int DIV_W      = 32,
  parameter int ZC_TOL     = 50,
  parameter int ZC_TIMEOUT = 65535
) (
  input  logic clk_100M,
  input  logic rst_n,
  keying_modulator_if.slave bus
);

  localparam int IDX_W = $clog2(SEQ_LEN);
  localparam int TO_W  = (ZC_TIMEOUT < 2) ? 1 : $clog2(ZC_TIMEOUT + 1);

  localparam logic [DATA_W-1:0] MID      = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W:0]   TOL      = (DATA_W+1)'(ZC_TOL);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(SEQ_LEN - 1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(ZC_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_WAIT_ZC, S_ADVANCE} state_t;

  state_t             r_state;
  logic [DIV_W-1:0]   r_timer;
  logic [TO_W-1:0]    r_to_cnt;
  logic [SEQ_LEN-1:0] r_shadow;
  logic [IDX_W-1:0]   r_bit_index;
  logic [DATA_W-1:0]  r_mod_sig;
  logic               r_symbol_strobe;
  logic               r_frame_done;
  logic               r_zc_timeout;

  logic [DATA_W:0]    w_diff;
  logic [DATA_W:0]    w_abs;
  logic               w_zc;
  logic [DIV_W-1:0]   w_term;
  logic               w_tc;
  logic               w_sym;
  logic [DATA_W-1:0]  w_half;
  logic [DATA_W-1:0]  w_keyed;

  // carrier - MID as a DATA_W+1 two's-complement value, so no unsigned wrap
  assign w_diff = {1'b0, bus.carrier} - {1'b0, MID};
  assign w_abs  = w_diff[DATA_W] ? (~w_diff + 1'b1) : w_diff;
  assign w_zc   = (w_abs <= TOL);

  assign w_term = (bus.symbol_div == '0) ? DIV_W'(1) : bus.symbol_div;
  assign w_tc   = (r_timer == w_term);

  assign w_sym  = r_shadow[r_bit_index];
  // MID + (diff >>> 1), truncated: the arithmetic shift is just diff[DATA_W:1]
  assign w_half = MID + w_diff[DATA_W:1];

  // Output keying selected by mode for the current bit
  always_comb begin
    w_keyed = MID;
    case (bus.mode)
      2'd0:    w_keyed = w_sym ? bus.carrier : MID;
      2'd1:    w_keyed = w_sym ? bus.carrier : w_half;
      2'd2:    w_keyed = w_sym ? bus.carrier : ~bus.carrier;
      default: w_keyed = MID;
    endcase
  end

  // Sequencer FSM, symbol timer, timeout counter and registered outputs.
  // Strobes are raised on entry to ADVANCE so they are visible during it,
  // alongside the bit that is finishing.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_timer         <= '0;
      r_to_cnt        <= '0;
      r_shadow        <= '0;
      r_bit_index     <= LAST_IDX;
      r_mod_sig       <= MID;
      r_symbol_strobe <= 1'b0;
      r_frame_done    <= 1'b0;
      r_zc_timeout    <= 1'b0;
    end else begin
      r_symbol_strobe <= 1'b0;
      r_frame_done    <= 1'b0;
      r_zc_timeout    <= 1'b0;
      if (!bus.enable) begin
        r_state   <= S_IDLE;
        r_timer   <= '0;
        r_mod_sig <= MID;
      end else begin
        r_mod_sig <= (r_state == S_IDLE) ? MID : w_keyed;
        if (r_state != S_IDLE) begin
          r_timer <= w_tc ? '0 : r_timer + 1'b1;
        end
        case (r_state)
          S_IDLE: begin
            r_shadow    <= bus.sequence_code;
            r_bit_index <= LAST_IDX;
            r_state     <= S_COUNT;
          end
          S_COUNT: begin
            if (w_tc) begin
              if (w_zc) begin
                r_state         <= S_ADVANCE;
                r_symbol_strobe <= 1'b1;
                r_frame_done    <= (r_bit_index == '0);
              end else begin
                r_state  <= S_WAIT_ZC;
                r_to_cnt <= '0;
              end
            end
          end
          S_WAIT_ZC: begin
            // timeout fires after ZC_TIMEOUT cycles spent waiting here
            if (w_zc || (r_to_cnt == TO_LAST)) begin
              r_state         <= S_ADVANCE;
              r_symbol_strobe <= 1'b1;
              r_frame_done    <= (r_bit_index == '0);
              r_zc_timeout    <= !w_zc;
            end else begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
          end
          S_ADVANCE: begin
            if (r_bit_index == '0) begin
              r_bit_index <= LAST_IDX;
              r_shadow    <= bus.sequence_code;
            end else begin
              r_bit_index <= r_bit_index - 1'b1;
            end
            r_state <= S_COUNT;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.mod_sig       = r_mod_sig;
  assign bus.sym_bit       = w_sym;
  assign bus.bit_index     = r_bit_index;
  assign bus.symbol_strobe = r_symbol_strobe;
  assign bus.frame_done    = r_frame_done;
  assign bus.zc_timeout    = r_zc_timeout;

endmodule

// File: tb/tb_keying_modulator.sv
// Scoreboard bench for keying_modulator: directed runs push expected symbol
// records; a negedge monitor pops one per symbol_strobe and compares.
module tb_keying_modulator;

  localparam int DW  = 16;
  localparam int SL  = 16;
  localparam int DVW = 32;
  localparam int TOL = 50;
  localparam int TMO = 20;

  logic clk_100M = 1'b0;
  logic rst_n    = 1'b0;
  always #5 clk_100M = ~clk_100M;

  keying_modulator_if #(.DATA_W(DW), .SEQ_LEN(SL), .DIV_W(DVW)) bus ();

  keying_modulator #(
    .DATA_W(DW), .SEQ_LEN(SL), .DIV_W(DVW), .ZC_TOL(TOL), .ZC_TIMEOUT(TMO)
  ) dut (
    .clk_100M(clk_100M),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [3:0]  idx;
    logic        bit_v;
    logic        fd;
    logic        to;
    logic [15:0] mod;
    logic        chk_mod;
    logic        chk_zc;
    int          gap;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int strobe_cnt = 0;
  int cyc = 0;
  int last_evt = 0;
  logic prev_en = 1'b0;
  logic [15:0] prev_car = 16'd32767;
  int tri_k = 0;
  int tri_dir = 1;
  int k;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // n expected symbols starting at bit index 'start' of 'code'
  task automatic push_run(input logic [15:0] code, input int start, input int n,
                          input logic [15:0] m1, input logic [15:0] m0,
                          input logic to, input int g0, input int g,
                          input logic chk_mod, input logic chk_zc);
    exp_t e;
    int idx = start;
    for (int i = 0; i < n; i++) begin
      e.idx     = 4'(idx);
      e.bit_v   = code[idx];
      e.fd      = (idx == 0);
      e.to      = to;
      e.mod     = code[idx] ? m1 : m0;
      e.chk_mod = chk_mod;
      e.chk_zc  = chk_zc;
      e.gap     = (i == 0) ? g0 : g;
      q.push_back(e);
      idx = (idx == 0) ? SL - 1 : idx - 1;
    end
  endtask

  // advance clocks until 'target' strobes seen; optional triangle carrier
  task automatic wait_strobes(input int target, input int budget, input bit tri_on);
    int c = 0;
    while (strobe_cnt < target && c < budget) begin
      @(posedge clk_100M); #2;
      if (tri_on) begin
        tri_k = tri_k + tri_dir;
        if (tri_k >= 5)  tri_dir = -1;
        if (tri_k <= -5) tri_dir = 1;
        bus.carrier = 16'(32767 + 50 * tri_k);
      end
      c++;
    end
    check("strobe_budget", strobe_cnt, target);
  endtask

  task automatic stop_run();
    bus.enable = 1'b0;
    repeat (2) @(posedge clk_100M);
    #1;
    check("idle_mod_sig", bus.mod_sig, 32767);
    check("queue_drained", q.size(), 0);
    repeat (3) @(posedge clk_100M);
    #2;
  endtask

  // Monitor: pop an expected record per strobe; no stray pulses otherwise
  always @(negedge clk_100M) begin
    exp_t e;
    cyc++;
    if (rst_n) begin
      if (bus.enable && !prev_en) last_evt = cyc;
      if (bus.symbol_strobe) begin
        strobe_cnt++;
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: got strobe at idx %0d, expected none", bus.bit_index);
        end else begin
          e = q.pop_front();
          check("bit_index", bus.bit_index, e.idx);
          check("sym_bit", bus.sym_bit, e.bit_v);
          check("frame_done", bus.frame_done, e.fd);
          check("zc_timeout", bus.zc_timeout, e.to);
          if (e.gap != 0) check("strobe_gap", cyc - last_evt, e.gap);
          if (e.chk_mod) check("mod_sig", bus.mod_sig, e.mod);
          if (e.chk_zc) begin
            int d = int'(prev_car) - 32767;
            if (d < 0) d = -d;
            check("zc_window", (d <= TOL) ? 1 : 0, 1);
          end
        end
        last_evt = cyc;
      end else begin
        check("stray_pulse", {bus.frame_done, bus.zc_timeout}, 0);
      end
    end
    prev_en  = bus.enable;
    prev_car = bus.carrier;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bus.enable        = 1'b0;
    bus.mode          = 2'd0;
    bus.symbol_div    = 32'd9;
    bus.carrier       = 16'd32767;
    bus.sequence_code = 16'h0000;

    // reset state
    repeat (3) @(posedge clk_100M);
    #1;
    check("rst_mod_sig", bus.mod_sig, 32767);
    check("rst_bit_index", bus.bit_index, 15);
    check("rst_sym_bit", bus.sym_bit, 0);
    check("rst_strobes", {bus.symbol_strobe, bus.frame_done, bus.zc_timeout}, 0);
    @(posedge clk_100M); #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk_100M);
    #1;
    check("idle_mod_sig", bus.mod_sig, 32767);
    check("idle_bit_index", bus.bit_index, 15);
    @(posedge clk_100M); #2;

    // OOK, carrier always inside the zero-crossing window
    bus.sequence_code = 16'hA5A5;
    bus.carrier       = 16'd32797;
    push_run(16'hA5A5, 15, 17, 16'd32797, 16'd32767, 1'b0, 11, 10, 1'b1, 1'b0);
    bus.enable = 1'b1;
    wait_strobes(strobe_cnt + 17, 400, 1'b0);
    stop_run();

    // carrier never crosses: every advance forced by timeout
    bus.sequence_code = 16'hC3A5;
    bus.carrier       = 16'd40000;
    push_run(16'hC3A5, 15, 4, 16'd40000, 16'd32767, 1'b1, 31, 30, 1'b1, 1'b0);
    bus.enable = 1'b1;
    wait_strobes(strobe_cnt + 4, 300, 1'b0);
    stop_run();

    // ASK half amplitude, then switch to BPSK mid-run without resequencing
    bus.sequence_code = 16'h5000;
    bus.carrier       = 16'd50000;
    bus.mode          = 2'd1;
    push_run(16'h5000, 15, 2, 16'd50000, 16'd41383, 1'b1, 31, 30, 1'b1, 1'b0);
    push_run(16'h5000, 13, 2, 16'd50000, 16'd15535, 1'b1, 30, 30, 1'b1, 1'b0);
    bus.enable = 1'b1;
    wait_strobes(strobe_cnt + 2, 200, 1'b0);
    bus.mode = 2'd2;
    wait_strobes(strobe_cnt + 2, 200, 1'b0);
    stop_run();

    // code word change mid-frame only takes effect after frame_done
    bus.mode          = 2'd0;
    bus.sequence_code = 16'hFFFF;
    bus.carrier       = 16'd32797;
    push_run(16'hFFFF, 15, 16, 16'd32797, 16'd32767, 1'b0, 11, 10, 1'b1, 1'b0);
    push_run(16'h0000, 15, 2, 16'd32797, 16'd32767, 1'b0, 10, 10, 1'b1, 1'b0);
    bus.enable = 1'b1;
    k = 0;
    while (bus.bit_index != 4'd7 && k < 300) begin
      @(posedge clk_100M); #2;
      k++;
    end
    check("reached_idx7", bus.bit_index, 7);
    bus.sequence_code = 16'h0000;
    wait_strobes(strobe_cnt + 10, 400, 1'b0);
    stop_run();

    // triangle carrier: advances only land on a mid-scale crossing
    bus.sequence_code = 16'hA5A5;
    tri_k   = 0;
    tri_dir = 1;
    bus.carrier = 16'd32767;
    push_run(16'hA5A5, 15, 6, 16'd0, 16'd0, 1'b0, 0, 0, 1'b0, 1'b1);
    bus.enable = 1'b1;
    wait_strobes(strobe_cnt + 6, 400, 1'b1);

    // asynchronous reset mid-frame
    rst_n      = 1'b0;
    bus.enable = 1'b0;
    #1;
    check("midrst_mod_sig", bus.mod_sig, 32767);
    check("midrst_bit_index", bus.bit_index, 15);
    check("midrst_sym_bit", bus.sym_bit, 0);
    check("midrst_strobes", {bus.symbol_strobe, bus.frame_done, bus.zc_timeout}, 0);
    @(posedge clk_100M); #2;
    rst_n = 1'b1;
    repeat (4) @(posedge clk_100M);
    #1;
    check("post_rst_mod_sig", bus.mod_sig, 32767);
    check("post_rst_bit_index", bus.bit_index, 15);
    check("post_rst_strobe", bus.symbol_strobe, 0);
    check("post_rst_queue", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
